// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Largest value representable in the given number of BCD digits (10^digits - 1).
    function automatic longint unsigned max_bcd_value(input int digits);
        longint unsigned v;
        v = 1;
        for (int i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, result with overflow flag and leading-zero mask.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     lz_mask
);

    localparam int                CNT_W    = $clog2(BIN_W + 1);
    localparam int                BCD_W    = 4 * DIGITS;
    localparam longint unsigned   MAX_VAL  = max_bcd_value(DIGITS);
    localparam logic [DIGITS-1:0] LZ_RESET = ~DIGITS'(1);

    state_t              state_reg,    state_next;
    logic [BIN_W-1:0]    operand_reg,  operand_next;
    logic [BCD_W-1:0]    work_reg,     work_next;
    logic [CNT_W-1:0]    count_reg,    count_next;
    logic                ovf_pend_reg, ovf_pend_next;
    logic [BCD_W-1:0]    bcd_out_reg,  bcd_out_next;
    logic                overflow_reg, overflow_next;
    logic [DIGITS-1:0]   lz_mask_reg,  lz_mask_next;

    logic [BCD_W-1:0]       adj_work;
    logic [BCD_W+BIN_W-1:0] shift_all;
    logic [BCD_W-1:0]       work_shift;
    logic [BIN_W-1:0]       op_shift;
    logic [DIGITS-1:0]      lz_calc;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_in  (work_reg[4*gi +: 4]),
                .digit_out (adj_work[4*gi +: 4])
            );
        end
    endgenerate

    // The carry out of the top digit falls off here, which yields the value modulo 10^DIGITS.
    assign shift_all  = {adj_work, operand_reg} << 1;
    assign work_shift = shift_all[BCD_W+BIN_W-1:BIN_W];
    assign op_shift   = shift_all[BIN_W-1:0];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
            if (gi == 0) begin : g_units
                assign lz_calc[gi] = 1'b0;
            end else begin : g_upper
                assign lz_calc[gi] = ~|work_shift[BCD_W-1:4*gi];
            end
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        operand_next  = operand_reg;
        work_next     = work_reg;
        count_next    = count_reg;
        ovf_pend_next = ovf_pend_reg;
        bcd_out_next  = bcd_out_reg;
        overflow_next = overflow_reg;
        lz_mask_next  = lz_mask_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next    = SHIFT;
                    operand_next  = bin_in;
                    work_next     = '0;
                    count_next    = CNT_W'(BIN_W);
                    ovf_pend_next = (64'(bin_in) > MAX_VAL);
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                operand_next = op_shift;
                work_next    = work_shift;
                count_next   = count_reg - CNT_W'(1);
                // Last shift: publish the result on the same edge that enters DONE.
                if (count_reg == CNT_W'(1)) begin
                    state_next    = DONE;
                    bcd_out_next  = work_shift;
                    overflow_next = ovf_pend_reg;
                    lz_mask_next  = lz_calc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            operand_reg  <= '0;
            work_reg     <= '0;
            count_reg    <= '0;
            ovf_pend_reg <= 1'b0;
            bcd_out_reg  <= '0;
            overflow_reg <= 1'b0;
            lz_mask_reg  <= LZ_RESET;
        end else begin
            state_reg    <= state_next;
            operand_reg  <= operand_next;
            work_reg     <= work_next;
            count_reg    <= count_next;
            ovf_pend_reg <= ovf_pend_next;
            bcd_out_reg  <= bcd_out_next;
            overflow_reg <= overflow_next;
            lz_mask_reg  <= lz_mask_next;
        end
    end

    assign busy     = (state_reg == SHIFT);
    assign done     = (state_reg == DONE);
    assign bcd_out  = bcd_out_reg;
    assign overflow = overflow_reg;
    assign lz_mask  = lz_mask_reg;

endmodule
